lcd_bus_arbiter: RTL and testbench

Shares the single HD44780 8-bit LCD transmitter between two byte-level requesters, e.g. the keypad-driven LCD command sequencer and a status/clock overlay writer. It forwards one byte (RS + data) at a time and issues the transmitter chip-select. It waits out the transmitter busy window and acknowledges the winning requester. Arbitration is round-robin, with an optional lock so multi-byte sequences (set-DDRAM-address followed by characters) are not interleaved.

---
 rtl/lcd_bus_arbiter_if.sv | 28 ++
 rtl/lcd_bus_arbiter.sv | 91 +++++++++
 tb/tb_lcd_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if: requester/transmitter bus shared by the LCD byte arbiter
// req/lock/req_rs : per-requester request, grant lock and RS select
// data0/data1     : requester bytes
// busy            : transmitter busy
// cs/lcd_rs/lcd_data : transfer strobe, RS and byte to the transmitter
// grant/ack/err   : one-hot owner, completion pulse, start-timeout pulse
interface lcd_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] req_rs;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       busy;
  logic       cs;
  logic       lcd_rs;
  logic [7:0] lcd_data;
  logic [1:0] grant;
  logic [1:0] ack;
  logic       err;
  modport master (
    output req, lock, req_rs, data0, data1, busy,
    input  cs, lcd_rs, lcd_data, grant, ack, err
  );
  modport slave (
    input  req, lock, req_rs, data0, data1, busy,
    output cs, lcd_rs, lcd_data, grant, ack, err
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin arbiter sharing one HD44780 byte transmitter between two requesters
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of lcd_bus_arbiter_if (requests, bytes, busy in; cs, byte, grant, ack, err out)
// START_TIMEOUT : cycles to wait for busy after cs before completing with err (2..255)
module lcd_bus_arbiter #(
  parameter int START_TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  lcd_bus_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE} state_t;
  state_t     state;
  logic       owner;
  logic       last;
  logic       locked;
  logic [7:0] cnt;
  logic       hold;
  logic       win_any;
  logic       win;
  // A held lock restricts eligibility to the owner; a dropped lock falls back to round-robin.
  always_comb begin
    hold    = locked && bus.lock[owner];
    win_any = !bus.busy && (hold ? bus.req[owner] : |bus.req);
    win     = hold ? owner : (&bus.req ? ~last : bus.req[1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      locked       <= 1'b0;
      cnt          <= 8'd0;
      bus.cs       <= 1'b0;
      bus.lcd_rs   <= 1'b0;
      bus.lcd_data <= 8'd0;
      bus.grant    <= 2'b00;
      bus.ack      <= 2'b00;
      bus.err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.busy) begin
            if (!hold) locked <= 1'b0;
            if (win_any) begin
              owner        <= win;
              bus.lcd_rs   <= bus.req_rs[win];
              bus.lcd_data <= win ? bus.data1 : bus.data0;
              bus.grant    <= {win, ~win};
              bus.cs       <= 1'b1;
              state        <= ISSUE;
            end else if (!hold) begin
              bus.grant <= 2'b00;
            end
          end
        end
        ISSUE: begin
          bus.cs <= 1'b0;
          cnt    <= 8'd0;
          state  <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.busy) begin
            state <= WAIT_DONE;
          end else if (cnt == 8'(START_TIMEOUT - 1)) begin
            bus.ack <= {owner, ~owner};
            bus.err <= 1'b1;
            state   <= COMPLETE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.busy) begin
            bus.ack <= {owner, ~owner};
            state   <= COMPLETE;
          end
        end
        COMPLETE: begin
          bus.ack <= 2'b00;
          bus.err <= 1'b0;
          last    <= owner;
          locked  <= bus.lock[owner];
          if (!bus.lock[owner]) bus.grant <= 2'b00;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed self-checking bench for lcd_bus_arbiter
module tb_lcd_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lcd_bus_arbiter_if bus();
  lcd_bus_arbiter #(.START_TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bcnt = 0;
  bit model_en = 1'b1;
  bit force_busy = 1'b0;
  // Transmitter model: busy for 10 cycles starting the cycle after cs.
  assign bus.busy = force_busy | (model_en & (bcnt != 0));
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    bcnt <= (bus.cs && model_en) ? 10 : (bcnt > 0 ? bcnt - 1 : 0);
  end
  logic [8:0] cs_log[$];
  int         cs_cyc[$];
  logic [1:0] ack_log[$];
  logic       err_log[$];
  int         ack_cyc[$];
  int         proto_bad = 0;
  logic [1:0] prev_ack = 2'b00;
  logic       prev_err = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cs) begin
        cs_log.push_back({bus.lcd_rs, bus.lcd_data});
        cs_cyc.push_back(cyc);
      end
      if (bus.ack != 2'b00) begin
        ack_log.push_back(bus.ack);
        err_log.push_back(bus.err);
        ack_cyc.push_back(cyc);
      end
      if (bus.ack == 2'b11 || (bus.ack != 2'b00 && prev_ack != 2'b00) ||
          (bus.err && prev_err) || (bus.err && bus.ack == 2'b00))
        proto_bad++;
    end
    prev_ack = bus.ack;
    prev_err = bus.err;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    tests++;
    if ({bus.cs, bus.lcd_rs, bus.lcd_data, bus.grant, bus.ack, bus.err} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", {bus.cs, bus.lcd_rs, bus.lcd_data, bus.grant, bus.ack, bus.err});
    end
    rst = 1'b0;
    tick(3);
    tests++;
    if ({bus.cs, bus.grant, bus.ack, bus.err} !== 6'd0) begin
      fails++;
      $display("FAIL reset_idle: got %h want 0", {bus.cs, bus.grant, bus.ack, bus.err});
    end
  endtask
  task automatic test_single;
    int b = cs_log.size();
    int a = ack_log.size();
    int gbad = 0;
    bit ok = 1'b0;
    bus.req_rs[0] = 1'b1;
    bus.data0 = 8'h41;
    bus.req[0] = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if ((bus.cs || cs_log.size() > b) && bus.grant !== 2'b01) gbad++;
      if (bus.ack[0]) begin
        ok = 1'b1;
        bus.req[0] = 1'b0;
      end
    end
    tick(2);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_ack_seen: got none want ack within 100 cycles"); end
    tests++;
    if (cs_log.size() - b !== 1) begin fails++; $display("FAIL single_cs_count: got %0d want 1", cs_log.size() - b); end
    tests++;
    if (cs_log.size() <= b || cs_log[b] !== 9'h141) begin fails++; $display("FAIL single_byte: got %h want 141", cs_log.size() > b ? cs_log[b] : 9'h1ff); end
    tests++;
    if (ack_log.size() - a !== 1 || ack_log[a] !== 2'b01) begin fails++; $display("FAIL single_ack: got count %0d want one 01 pulse", ack_log.size() - a); end
    tests++;
    if (err_log.size() <= a || err_log[a] !== 1'b0) begin fails++; $display("FAIL single_err: got 1 want 0"); end
    tests++;
    if (ack_log.size() <= a || cs_log.size() <= b || ack_cyc[a] - cs_cyc[b] !== 12) begin fails++; $display("FAIL single_latency: got %0d want 12", (ack_log.size() > a && cs_log.size() > b) ? ack_cyc[a] - cs_cyc[b] : -1); end
    tests++;
    if (gbad !== 0) begin fails++; $display("FAIL single_grant_held: got %0d bad cycles want 0", gbad); end
    tests++;
    if (bus.grant !== 2'b00) begin fails++; $display("FAIL single_grant_release: got %b want 00", bus.grant); end
  endtask
  task automatic test_round_robin;
    logic [7:0] exp_d [4] = '{8'h30, 8'h31, 8'h30, 8'h31};
    logic [1:0] exp_a [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int b;
    int a;
    int n = 0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    b = cs_log.size();
    a = ack_log.size();
    bus.req_rs = 2'b00;
    bus.data0 = 8'h30;
    bus.data1 = 8'h31;
    bus.req = 2'b11;
    for (int i = 0; i < 200 && n < 4; i++) begin
      tick(1);
      if (bus.ack != 2'b00) n++;
      if (n == 4) bus.req = 2'b00;
    end
    bus.req = 2'b00;
    tick(15);
    tests++;
    if (cs_log.size() - b !== 4) begin fails++; $display("FAIL rr_count: got %0d want 4", cs_log.size() - b); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (cs_log.size() <= b + i || cs_log[b + i] !== {1'b0, exp_d[i]} ||
          ack_log.size() <= a + i || ack_log[a + i] !== exp_a[i]) begin
        fails++;
        $display("FAIL rr_byte%0d: got %h/%b want %h/%b", i, cs_log.size() > b + i ? cs_log[b + i] : 9'h1ff,
                 ack_log.size() > a + i ? ack_log[a + i] : 2'b11, {1'b0, exp_d[i]}, exp_a[i]);
      end
    end
  endtask
  task automatic test_lock;
    logic [8:0] exp_d [4] = '{9'h080, 9'h148, 9'h149, 9'h155};
    logic [1:0] exp_a [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    int b = cs_log.size();
    int a = ack_log.size();
    int idx = 0;
    bit done = 1'b0;
    bus.req_rs[1] = 1'b0;
    bus.data1 = 8'h80;
    bus.lock[1] = 1'b1;
    bus.req[1] = 1'b1;
    tick(3);
    bus.req_rs[0] = 1'b1;
    bus.data0 = 8'h55;
    bus.req[0] = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      tick(1);
      if (bus.ack[1]) begin
        idx++;
        if (idx == 1) begin
          bus.data1 = 8'h48;
          bus.req_rs[1] = 1'b1;
        end else if (idx == 2) begin
          bus.data1 = 8'h49;
        end else begin
          bus.req[1] = 1'b0;
          bus.lock[1] = 1'b0;
        end
      end
      if (bus.ack[0]) begin
        bus.req[0] = 1'b0;
        done = 1'b1;
      end
    end
    bus.req = 2'b00;
    bus.lock = 2'b00;
    tick(2);
    tests++;
    if (!done) begin fails++; $display("FAIL lock_done: got no requester-0 ack want one"); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (cs_log.size() <= b + i || cs_log[b + i] !== exp_d[i] ||
          ack_log.size() <= a + i || ack_log[a + i] !== exp_a[i]) begin
        fails++;
        $display("FAIL lock_byte%0d: got %h/%b want %h/%b", i, cs_log.size() > b + i ? cs_log[b + i] : 9'h1ff,
                 ack_log.size() > a + i ? ack_log[a + i] : 2'b11, exp_d[i], exp_a[i]);
      end
    end
  endtask
  task automatic test_timeout;
    int b = cs_log.size();
    int a = ack_log.size();
    bit ok = 1'b0;
    model_en = 1'b0;
    bus.req_rs[0] = 1'b0;
    bus.data0 = 8'h11;
    bus.req[0] = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick(1);
      if (bus.ack[0]) begin
        ok = 1'b1;
        bus.req[0] = 1'b0;
      end
    end
    tick(1);
    tests++;
    if ({bus.cs, bus.grant, bus.ack, bus.err} !== 6'd0) begin fails++; $display("FAIL timeout_idle: got %h want 0", {bus.cs, bus.grant, bus.ack, bus.err}); end
    tick(1);
    tests++;
    if (!ok || ack_log.size() <= a || ack_log[a] !== 2'b01 || err_log[a] !== 1'b1) begin fails++; $display("FAIL timeout_ack_err: got ack/err missing or wrong want 01/1"); end
    tests++;
    if (ack_log.size() <= a || cs_log.size() <= b || ack_cyc[a] - cs_cyc[b] !== 9) begin fails++; $display("FAIL timeout_latency: got %0d want 9", (ack_log.size() > a && cs_log.size() > b) ? ack_cyc[a] - cs_cyc[b] : -1); end
    model_en = 1'b1;
  endtask
  task automatic test_busy_gating;
    int b = cs_log.size();
    int fall;
    bit ok = 1'b0;
    force_busy = 1'b1;
    bus.req_rs[0] = 1'b1;
    bus.data0 = 8'h22;
    bus.req[0] = 1'b1;
    tick(6);
    tests++;
    if (cs_log.size() !== b) begin fails++; $display("FAIL gate_no_cs: got %0d strobes want 0", cs_log.size() - b); end
    fall = cyc;
    force_busy = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (bus.ack[0]) begin
        ok = 1'b1;
        bus.req[0] = 1'b0;
      end
    end
    tick(2);
    tests++;
    if (!ok || cs_log.size() <= b || cs_cyc[b] !== fall + 1 || cs_log[b] !== 9'h122) begin
      fails++;
      $display("FAIL gate_release: got cycle %0d want %0d", cs_log.size() > b ? cs_cyc[b] : -1, fall + 1);
    end
  endtask
  task automatic test_reset_mid;
    int b = cs_log.size();
    int a;
    bit seen = 1'b0;
    bit ok = 1'b0;
    logic [1:0] g = 2'b00;
    bus.req_rs = 2'b00;
    bus.data0 = 8'h66;
    bus.req[0] = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (bus.cs) seen = 1'b1;
    end
    tick(3);
    rst = 1'b1;
    bus.req = 2'b00;
    tick(1);
    tests++;
    if ({bus.cs, bus.lcd_rs, bus.lcd_data, bus.grant, bus.ack, bus.err} !== 15'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got %h want 0", {bus.cs, bus.lcd_rs, bus.lcd_data, bus.grant, bus.ack, bus.err});
    end
    rst = 1'b0;
    a = ack_log.size();
    bus.data0 = 8'h70;
    bus.data1 = 8'h71;
    bus.req = 2'b11;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (bus.cs) g = bus.grant;
      if (bus.ack != 2'b00) begin
        ok = 1'b1;
        bus.req = 2'b00;
      end
    end
    tick(2);
    tests++;
    if (!seen || cs_log.size() < b + 2 || cs_log[b + 1] !== 9'h070 || g !== 2'b01) begin
      fails++;
      $display("FAIL midreset_tie: got %h grant %b want 070 grant 01", cs_log.size() >= b + 2 ? cs_log[b + 1] : 9'h1ff, g);
    end
    tests++;
    if (cs_log.size() < b + 2 || cs_cyc[b + 1] - cs_cyc[b] !== 12) begin
      fails++;
      $display("FAIL midreset_busy_block: got %0d want 12", cs_log.size() >= b + 2 ? cs_cyc[b + 1] - cs_cyc[b] : -1);
    end
    tests++;
    if (ack_log.size() - a !== 1 || ack_log[a] !== 2'b01) begin
      fails++;
      $display("FAIL midreset_ack: got %0d acks want exactly one 01", ack_log.size() - a);
    end
  endtask
  task automatic test_protocol;
    tests++;
    if (proto_bad !== 0) begin fails++; $display("FAIL ack_err_pulse_rules: got %0d violations want 0", proto_bad); end
  endtask
  initial begin
    bus.req = 2'b00;
    bus.lock = 2'b00;
    bus.req_rs = 2'b00;
    bus.data0 = 8'h00;
    bus.data1 = 8'h00;
    test_reset;
    test_single;
    test_round_robin;
    test_lock;
    test_timeout;
    test_busy_gating;
    test_reset_mid;
    test_protocol;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
